// File: rtl/joy_pkg.sv
// Shared types and constants for the joystick share scheduler and the
// processing core it feeds.
package joy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } joy_state_e;

    // Direction nibble ordering is {up,down,left,right}
    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    localparam logic [3:0] DIR_VERTICAL   = DIR_UP | DIR_DOWN;
    localparam logic [3:0] DIR_HORIZONTAL = DIR_LEFT | DIR_RIGHT;

    localparam logic [3:0] MODE_DISABLED   = 4'd0;
    localparam logic [3:0] MODE_PREDICTION = 4'd1;
    localparam logic [3:0] MODE_CORRECTION = 4'd2;
    localparam logic [3:0] MODE_VERTICAL   = 4'd3;
    localparam logic [3:0] MODE_HORIZONTAL = 4'd4;
    localparam logic [3:0] MODE_CLEAR      = 4'd5;

    localparam logic FAVOR_HORIZONTAL = 1'b0;
    localparam logic FAVOR_VERTICAL   = 1'b1;

endpackage

// File: rtl/joy_share_scheduler_rr_arbiter.sv
// Round-robin selector: picks the first requester strictly after last_grant,
// wrapping around, so the most recently served player is searched last.
module rr_arbiter #(
    parameter int NPLAYER = 4,
    parameter int IW      = $clog2(NPLAYER)
) (
    input  logic [NPLAYER-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_any
);

    logic [IW-1:0] cand;

    // Walk from the farthest offset down so the nearest requester wins
    always_comb begin
        grant_idx = last_grant;
        grant_any = 1'b0;
        cand      = '0;
        for (int off = NPLAYER; off >= 1; off--) begin
            cand = IW'((int'(last_grant) + off) % NPLAYER);
            if (req[cand]) begin
                grant_idx = cand;
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/joy_share_scheduler.sv
// Time-shares one processing core among NPLAYER joystick ports: synchronizes
// inputs, tracks changed players, and runs one core transaction at a time.
module joy_share_scheduler
    import joy_pkg::*;
#(
    parameter int NPLAYER  = 4,
    parameter int CORE_LAT = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [4*NPLAYER-1:0]   dir_in,
    input  logic [4*NPLAYER-1:0]   mode_in,
    output logic                   core_valid,
    output logic [3:0]             core_dir,
    output logic [3:0]             core_last,
    output logic [3:0]             core_mode,
    input  logic [3:0]             core_result,
    output logic [4*NPLAYER-1:0]   dir_out,
    output logic [NPLAYER-1:0]     dir_upd,
    output logic                   busy
);

    localparam int IW = $clog2(NPLAYER);
    typedef logic [NPLAYER-1:0][3:0] lane_vec_t;

    joy_state_e         state_q, state_d;
    lane_vec_t          dir_s1_q, dir_s1_d, dir_s2_q, dir_s2_d;
    lane_vec_t          mode_s1_q, mode_s1_d;
    lane_vec_t          dir_out_q, dir_out_d;
    logic [NPLAYER-1:0] pending_q, pending_d;
    logic [NPLAYER-1:0] dir_upd_q, dir_upd_d;
    logic [IW-1:0]      cur_q, cur_d;
    logic [IW-1:0]      grant_idx;
    logic               grant_any;
    logic [3:0]         snap_dir_q, snap_dir_d;
    logic [3:0]         snap_mode_q, snap_mode_d;
    logic [2:0]         wait_cnt_q, wait_cnt_d;

    // cur_q doubles as the round-robin pointer and the player in service
    rr_arbiter #(.NPLAYER(NPLAYER)) u_arb (
        .req        (pending_q),
        .last_grant (cur_q),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    always_comb begin
        state_d     = state_q;
        dir_s1_d    = dir_in;
        dir_s2_d    = dir_s1_q;
        mode_s1_d   = mode_in;
        dir_out_d   = dir_out_q;
        pending_d   = pending_q;
        dir_upd_d   = '0;
        cur_d       = cur_q;
        snap_dir_d  = snap_dir_q;
        snap_mode_d = snap_mode_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    cur_d       = grant_idx;
                    snap_dir_d  = dir_s1_q[grant_idx];
                    snap_mode_d = mode_s1_q[grant_idx];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = 3'd1;
                state_d    = (CORE_LAT == 1) ? ST_CAPTURE : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == 3'(CORE_LAT - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            ST_CAPTURE: begin
                dir_out_d[cur_q] = core_result;
                dir_upd_d[cur_q] = 1'b1;
                // A player that moved since the snapshot stays pending
                if (dir_s1_q[cur_q] == snap_dir_q) begin
                    pending_d[cur_q] = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        for (int p = 0; p < NPLAYER; p++) begin
            if (dir_s1_q[p] != dir_s2_q[p]) begin
                pending_d[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dir_s1_q    <= '0;
            dir_s2_q    <= '0;
            mode_s1_q   <= '0;
            dir_out_q   <= '0;
            pending_q   <= '0;
            dir_upd_q   <= '0;
            cur_q       <= IW'(NPLAYER - 1);
            snap_dir_q  <= '0;
            snap_mode_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dir_s1_q    <= dir_s1_d;
            dir_s2_q    <= dir_s2_d;
            mode_s1_q   <= mode_s1_d;
            dir_out_q   <= dir_out_d;
            pending_q   <= pending_d;
            dir_upd_q   <= dir_upd_d;
            cur_q       <= cur_d;
            snap_dir_q  <= snap_dir_d;
            snap_mode_q <= snap_mode_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign core_valid = (state_q == ST_ISSUE);
    assign core_dir   = core_valid ? snap_dir_q : 4'd0;
    assign core_last  = core_valid ? dir_out_q[cur_q] : 4'd0;
    assign core_mode  = core_valid ? snap_mode_q : 4'd0;
    assign dir_out    = dir_out_q;
    assign dir_upd    = dir_upd_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/joy_share_scheduler.md
JOY_SHARE_SCHEDULER -- requirements
Module: joy_share_scheduler

Interface
REQ-001 SHALL have parameter NPLAYER, default 4, meaning the number of player ports sharing one 4-way processing core (legal 2..4).
REQ-002 SHALL have parameter CORE_LAT, default 2, meaning the core's fixed result latency in cycles (legal 1..7).
REQ-003 SHALL have port clock  input  1  meaning the sole clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port dir_in  input  4*NPLAYER  meaning raw directions; player p is at [4p+3:4p], ordered {up,down,left,right}.
REQ-006 SHALL have port mode_in  input  4*NPLAYER  meaning per-player 4-bit user mode, packed the same way as dir_in.
REQ-007 SHALL have port core_valid  output  1  meaning a one-cycle issue strobe to the core.
REQ-008 SHALL have port core_dir  output  4  meaning the snapshot direction of the granted player.
REQ-009 SHALL have port core_last  output  4  meaning the granted player's last processed output.
REQ-010 SHALL have port core_mode  output  4  meaning the snapshot mode of the granted player.
REQ-011 SHALL have port core_result  input  4  meaning the core result, valid exactly CORE_LAT cycles after core_valid.
REQ-012 SHALL have port dir_out  output  4*NPLAYER  meaning the registered processed directions for each player.
REQ-013 SHALL have port dir_upd  output  NPLAYER  meaning a one-cycle pulse per player when its dir_out is written.
REQ-014 SHALL have port busy  output  1  meaning high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL pass each player's dir_in and mode_in through a two-register synchronizer (sync1 then sync2).
REQ-016 SHALL set pending[p] in any cycle where sync2 of player p's direction differs from sync1.
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT and CAPTURE.
REQ-018 In IDLE with any pending bit set, SHALL grant round-robin, searching upward (with wrap) from the player after the last granted one, and go to ISSUE.
REQ-019 On grant, SHALL latch the player's sync1 direction and mode as the snapshot.
REQ-020 In ISSUE, SHALL hold core_valid at 1 for exactly one cycle, drive core_dir, core_last and core_mode from the snapshot, then go to WAIT.
REQ-021 SHALL count CORE_LAT-1 cycles in WAIT, or skip WAIT entirely when CORE_LAT=1, and then enter CAPTURE.
REQ-022 In CAPTURE, SHALL sample core_result into dir_out[p] and pulse dir_upd[p], so dir_out is visible CORE_LAT+1 cycles after the ISSUE cycle; it SHALL then return to IDLE.
REQ-023 In CAPTURE, SHALL clear pending[p] only if the current sync1 equals the snapshot; if a change occurs in the same cycle, setting pending wins over clearing.
REQ-024 SHALL hold core_dir, core_last and core_mode at 0 outside ISSUE.
REQ-025 SHALL keep at most one transaction outstanding; there is no pipelining.
REQ-026 Worst-case service latency SHALL be bounded by NPLAYER*(CORE_LAT+2) cycles after pending is set.
REQ-027 Mode changes with no direction change SHALL NOT set pending; they take effect at the next issue.

Reset
REQ-028 Asserting reset_n low SHALL immediately force: state IDLE, core_valid 0, dir_out 0, dir_upd 0, busy 0, all pending bits 0, all synchronizers 0, and the round-robin pointer at player NPLAYER-1 (so player 0 is searched first).
REQ-029 Reset asserted mid-transaction SHALL abandon that transaction; a core result arriving later SHALL be ignored.
REQ-030 After reset deasserts, any non-zero input SHALL become pending through the normal synchronizer path.

Structure
REQ-031 Package joy_pkg SHALL hold: the FSM state enum; DIR_UP/DOWN/LEFT/RIGHT bit masks; MODE_* codes (DISABLED, PREDICTION, CORRECTION, VERTICAL, HORIZONTAL, CLEAR); the FAVOR_* and DIR_HORIZONTAL/VERTICAL constants.
REQ-032 The round-robin selector SHALL be a separate sub-module, rr_arbiter, with inputs req[NPLAYER] and last_grant and outputs grant_idx and grant_any.

Verification
REQ-033 Bench, CORE_LAT=2: player 1 dir 0000->1000 -> one core_valid with core_dir=1000 and core_last=0000; dir_out[1] updates with dir_upd[1] 3 cycles after the ISSUE cycle.
REQ-034 Bench: players 0, 2 and 3 change in the same cycle after reset -> grants in order 0, 2, 3, with no idle cycle between CAPTURE and the next ISSUE beyond one IDLE cycle.
REQ-035 Bench: player 2 input changes 0100->0110 during its own WAIT -> pending[2] stays set; a second transaction issues with core_dir=0110 and core_last equal to the first result.
REQ-036 Bench: reset_n pulled low during WAIT -> outputs are 0 within the same cycle; the later core_result is ignored and dir_upd stays 0.
REQ-037 Bench, CORE_LAT=1 and NPLAYER=2: both players toggle continuously -> grants alternate 0,1,0,1 and each player is served within 6 cycles.
REQ-038 Bench: mode_in changes alone -> no core_valid; the next direction change then issues with the new core_mode.
